control_regs: RTL and testbench
===============================

Name: control_regs

Overview:
- Host-writable control/configuration register bank for the BFS accelerator; the write-side counterpart of the read-only status register block.
- Decodes single-cycle bus writes and holds the traversal configuration.
- Issues one-cycle start and soft-reset pulses to the BFS engine.
- Tracks engine run state, locks configuration while running, and raises a latched completion interrupt.

Parameters:
- ADDR_WIDTH, 12, byte address width of bus interface
- DATA_WIDTH, 32, register/bus data width (fixed 32; strobe width DATA_WIDTH/8)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- addr  in  ADDR_WIDTH  byte address for write and read-back
- wr_en  in  1  write qualifier, one write per asserted cycle
- wr_data  in  DATA_WIDTH  write data
- wr_strb  in  DATA_WIDTH/8  byte enables; byte i written only if wr_strb[i]
- rd_data  out  DATA_WIDTH  combinational read-back of addr
- busy  in  1  engine running
- done  in  1  engine done level
- start_pulse  out  1  one-cycle traversal start
- soft_reset_pulse  out  1  one-cycle engine abort/reset
- root_node  out  32  root vertex ID
- num_nodes  out  32  vertex count
- graph_base  out  32  graph base byte address
- irq  out  1  interrupt, level = irq_pending & irq_en

Behaviour:
- Register map (other addresses: writes ignored, read 0):
  - 0x000 CTRL: bit0 START (W1, reads 0); bit1 SOFT_RESET (W1, reads 0); bit2 IRQ_EN (RW); bit8 START_REJECTED (sticky, W1C); bits 17:16 state (RO).
  - 0x004 ROOT_NODE (RW).
  - 0x008 NUM_NODES (RW).
  - 0x00C GRAPH_BASE (RW; bits 1:0 forced 0).
  - 0x01C IRQ_STATUS: bit0 irq_pending (W1C).
- Reset values: all registers, start_pulse, soft_reset_pulse, irq = 0; state = IDLE.
- FSM, state encoding 0 IDLE, 1 LAUNCH, 2 RUN, 3 DRAIN:
  - IDLE: valid START write -> LAUNCH.
  - LAUNCH: start_pulse = 1 for exactly this cycle -> RUN.
  - RUN: wait for busy rising; on busy = 0 after having seen busy = 1 -> DRAIN.
  - RUN watchdog: if busy is never seen within 16 cycles of LAUNCH and done = 1, treat as complete -> DRAIN.
  - DRAIN: set irq_pending (one cycle) -> IDLE.
- start_pulse and soft_reset_pulse are registered outputs; START/SOFT_RESET writes produce pulses the next cycle. Latency from write cycle to start_pulse = 1 cycle.
- START write when state != IDLE: ignored, sets START_REJECTED; no pulse.
- Config lock: writes to 0x004/0x008/0x00C while state != IDLE are dropped and set START_REJECTED.
- START with num_nodes == 0 or root_node >= num_nodes: rejected, sets START_REJECTED, stays IDLE.
- Same-write config+START is impossible (different addresses); a config write in the same cycle the FSM leaves IDLE is not possible because writes are sequential.
- SOFT_RESET write (any state):
  - soft_reset_pulse next cycle; FSM -> IDLE; irq_pending unchanged; config retained.
  - If START and SOFT_RESET are both set in one write, SOFT_RESET wins; no start.
- irq_pending set and W1C in the same cycle: set wins.
- IRQ_EN only gates irq; it does not gate irq_pending.
- START_REJECTED set and W1C in the same cycle: set wins.
- Partial strobes: only enabled bytes update; W1 action bits act only if byte 0 is enabled.
- Asynchronous reset mid-run: everything returns to reset values immediately; no pulses emitted.

Test Plan:
- Reset, then read 0x000/0x004/0x008/0x00C/0x01C -> all 0, irq = 0, start_pulse = 0.
- Write ROOT_NODE = 5, NUM_NODES = 100, GRAPH_BASE = 0x1000_0003 -> reads 5, 100, 0x1000_0000. Write 0x004 with wr_strb = 4'b0010, data 0xAABBCCDD -> reads 0x0000_CC05.
- CTRL = 0x5 (START | IRQ_EN) -> start_pulse high exactly 1 cycle, 1 cycle after write. Drive busy high 10 cycles then low -> irq_pending = 1, irq = 1, state back to 0. W1C 0x01C -> irq = 0.
- While busy: write START and ROOT_NODE = 7 -> no start_pulse, ROOT_NODE still 5, CTRL bit8 = 1. W1C bit8 -> 0.
- NUM_NODES = 0, START -> no pulse, START_REJECTED = 1, state IDLE.
- During RUN, CTRL = 0x3 -> soft_reset_pulse 1 cycle, no start_pulse, state IDLE, config unchanged, irq_pending not set. Separately, assert rst_n low mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/control_regs.sv
// control_regs
// Host-writable control/configuration register bank for the BFS engine.
// Decodes single-cycle bus writes, holds the traversal configuration,
// issues one-cycle start / soft-reset pulses and raises a latched
// completion interrupt.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   addr              byte address for writes and combinational read-back
//   wr_en             write qualifier (one write per asserted cycle)
//   wr_data, wr_strb  write data and byte enables
//   rd_data           combinational read-back of addr
//   busy, done        engine status inputs
//   start_pulse       registered one-cycle traversal start
//   soft_reset_pulse  registered one-cycle engine abort
//   root_node, num_nodes, graph_base  traversal configuration
//   irq               irq_pending & irq_en
//
// Register map:
//   0x000 CTRL       bit0 START (W1), bit1 SOFT_RESET (W1), bit2 IRQ_EN,
//                    bit8 START_REJECTED (W1C), bits17:16 FSM state
//   0x004 ROOT_NODE  0x008 NUM_NODES  0x00C GRAPH_BASE (bits 1:0 read 0)
//   0x01C IRQ_STATUS bit0 irq_pending (W1C)
module control_regs #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  output logic [DATA_WIDTH-1:0]   rd_data,
  input  logic                    busy,
  input  logic                    done,
  output logic                    start_pulse,
  output logic                    soft_reset_pulse,
  output logic [DATA_WIDTH-1:0]   root_node,
  output logic [DATA_WIDTH-1:0]   num_nodes,
  output logic [DATA_WIDTH-1:0]   graph_base,
  output logic                    irq
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL = ADDR_WIDTH'('h000);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ROOT = ADDR_WIDTH'('h004);
  localparam logic [ADDR_WIDTH-1:0] ADDR_NUM  = ADDR_WIDTH'('h008);
  localparam logic [ADDR_WIDTH-1:0] ADDR_BASE = ADDR_WIDTH'('h00C);
  localparam logic [ADDR_WIDTH-1:0] ADDR_IRQ  = ADDR_WIDTH'('h01C);
  localparam logic [4:0] WD_LIMIT = 5'd16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t                  state_reg, state_next;
  logic                    seen_busy_reg;
  logic [4:0]              wd_cnt_reg;
  logic                    irq_en_reg, start_rejected_reg, irq_pending_reg;
  logic                    start_pulse_reg, soft_reset_pulse_reg;
  logic [DATA_WIDTH-1:0]   root_reg, num_reg, base_reg;
  logic [DATA_WIDTH-1:0]   root_next, num_next, base_next;

  // Write decode
  logic sel_ctrl, sel_root, sel_num, sel_base, sel_irq;
  logic start_req, soft_req, start_ok, start_bad, cfg_locked, cfg_bad;

  assign sel_ctrl = wr_en && (addr == ADDR_CTRL);
  assign sel_root = wr_en && (addr == ADDR_ROOT);
  assign sel_num  = wr_en && (addr == ADDR_NUM);
  assign sel_base = wr_en && (addr == ADDR_BASE);
  assign sel_irq  = wr_en && (addr == ADDR_IRQ);

  // Action bits live in byte 0, so they only fire when that lane is enabled.
  assign start_req = sel_ctrl && wr_strb[0] && wr_data[0];
  assign soft_req  = sel_ctrl && wr_strb[0] && wr_data[1];

  // Soft reset overrides a START carried in the same write.
  assign start_ok  = start_req && !soft_req && (state_reg == IDLE) &&
                     (num_reg != '0) && (root_reg < num_reg);
  assign start_bad = start_req && !soft_req && !start_ok;

  assign cfg_locked = (state_reg != IDLE);
  assign cfg_bad    = (sel_root || sel_num || sel_base) && cfg_locked;

  // Byte-lane merge for the configuration registers.
  generate
    for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_cfg_byte
      localparam logic [7:0] BASE_MASK = (gi == 0) ? 8'hFC : 8'hFF;
      assign root_next[gi*8 +: 8] = (sel_root && !cfg_locked && wr_strb[gi]) ?
                                    wr_data[gi*8 +: 8] : root_reg[gi*8 +: 8];
      assign num_next[gi*8 +: 8]  = (sel_num && !cfg_locked && wr_strb[gi]) ?
                                    wr_data[gi*8 +: 8] : num_reg[gi*8 +: 8];
      // Graph base is word aligned; the two low bits are never stored.
      assign base_next[gi*8 +: 8] = (sel_base && !cfg_locked && wr_strb[gi]) ?
                                    (wr_data[gi*8 +: 8] & BASE_MASK) :
                                    base_reg[gi*8 +: 8];
    end
  endgenerate

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (start_ok) state_next = LAUNCH;
      LAUNCH: state_next = RUN;
      RUN: begin
        if (seen_busy_reg && !busy)
          state_next = DRAIN;
        // Engine finished without ever raising busy: accept done once the
        // watchdog window has elapsed.
        else if (!seen_busy_reg && !busy && (wd_cnt_reg == WD_LIMIT) && done)
          state_next = DRAIN;
      end
      DRAIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (soft_req) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg            <= IDLE;
      seen_busy_reg        <= 1'b0;
      wd_cnt_reg           <= '0;
      irq_en_reg           <= 1'b0;
      start_rejected_reg   <= 1'b0;
      irq_pending_reg      <= 1'b0;
      start_pulse_reg      <= 1'b0;
      soft_reset_pulse_reg <= 1'b0;
      root_reg             <= '0;
      num_reg              <= '0;
      base_reg             <= '0;
    end else begin
      state_reg            <= state_next;
      start_pulse_reg      <= start_ok;
      soft_reset_pulse_reg <= soft_req;
      root_reg             <= root_next;
      num_reg              <= num_next;
      base_reg             <= base_next;

      // Busy tracking and watchdog restart on every launch.
      if (state_reg == LAUNCH || state_reg == RUN) begin
        if (busy) seen_busy_reg <= 1'b1;
        if (wd_cnt_reg != WD_LIMIT) wd_cnt_reg <= wd_cnt_reg + 5'd1;
      end else begin
        seen_busy_reg <= 1'b0;
        wd_cnt_reg    <= '0;
      end

      if (sel_ctrl && wr_strb[0]) irq_en_reg <= wr_data[2];

      // Setting takes priority over a simultaneous write-1-to-clear.
      if (start_bad || cfg_bad)
        start_rejected_reg <= 1'b1;
      else if (sel_ctrl && wr_strb[1] && wr_data[8])
        start_rejected_reg <= 1'b0;

      if (state_reg == DRAIN)
        irq_pending_reg <= 1'b1;
      else if (sel_irq && wr_strb[0] && wr_data[0])
        irq_pending_reg <= 1'b0;
    end
  end

  // Read-back
  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_CTRL: begin
        rd_data[17:16] = state_reg;
        rd_data[8]     = start_rejected_reg;
        rd_data[2]     = irq_en_reg;
      end
      ADDR_ROOT: rd_data = root_reg;
      ADDR_NUM:  rd_data = num_reg;
      ADDR_BASE: rd_data = base_reg;
      ADDR_IRQ:  rd_data[0] = irq_pending_reg;
      default:   rd_data = '0;
    endcase
  end

  assign start_pulse      = start_pulse_reg;
  assign soft_reset_pulse = soft_reset_pulse_reg;
  assign root_node        = root_reg;
  assign num_nodes        = num_reg;
  assign graph_base       = base_reg;
  assign irq              = irq_pending_reg && irq_en_reg;

endmodule

// File: tb/tb_control_regs.sv
module tb_control_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] addr = '0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_strb = '0;
  logic [31:0] rd_data;
  logic        busy = 1'b0;
  logic        done = 1'b0;
  logic        start_pulse, soft_reset_pulse, irq;
  logic [31:0] root_node, num_nodes, graph_base;

  control_regs #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wr_en(wr_en),
    .wr_data(wr_data), .wr_strb(wr_strb), .rd_data(rd_data),
    .busy(busy), .done(done), .start_pulse(start_pulse),
    .soft_reset_pulse(soft_reset_pulse), .root_node(root_node),
    .num_nodes(num_nodes), .graph_base(graph_base), .irq(irq)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // One bus write, issued on the falling edge; returns 1 ns after the
  // capturing rising edge, i.e. inside the cycle where pulses appear.
  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    addr = a; wr_data = d; wr_strb = s; wr_en = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    $display("wr  addr=0x%03h data=0x%08h strb=%b", a, d, s);
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rd_data;
  endtask

  task automatic wait_irq(input int max_cycles);
    int n;
    n = 0;
    while (irq !== 1'b1 && n < max_cycles) begin
      @(posedge clk); #1; n++;
    end
    chk("irq_rise", 32'(irq), 32'd1);
  endtask

  typedef struct {
    string       name;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [11:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  // Reference model state for the randomized phase
  logic [31:0] m_root, m_num, m_base;
  logic        m_irq_en, m_rej, m_pend;

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h000: return (32'(m_rej) << 8) | (32'(m_irq_en) << 2);
      12'h004: return m_root;
      12'h008: return m_num;
      12'h00C: return m_base;
      12'h01C: return 32'(m_pend);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  logic [31:0] v;
  int          cyc;

  initial begin
    vecs[0]  = '{"root_wr",     12'h004, 32'd5,         4'hF,    12'h004, 32'd5};
    vecs[1]  = '{"num_wr",      12'h008, 32'd100,       4'hF,    12'h008, 32'd100};
    vecs[2]  = '{"base_align",  12'h00C, 32'h1000_0003, 4'hF,    12'h00C, 32'h1000_0000};
    vecs[3]  = '{"root_strb1",  12'h004, 32'hAABB_CCDD, 4'b0010, 12'h004, 32'h0000_CC05};
    vecs[4]  = '{"root_restore",12'h004, 32'd5,         4'hF,    12'h004, 32'd5};
    vecs[5]  = '{"unmapped",    12'h010, 32'hFFFF_FFFF, 4'hF,    12'h010, 32'h0};
    vecs[6]  = '{"irq_en_set",  12'h000, 32'h4,         4'hF,    12'h000, 32'h4};
    vecs[7]  = '{"ctrl_byte1",  12'h000, 32'h0,         4'b0010, 12'h000, 32'h4};
    vecs[8]  = '{"irq_en_clr",  12'h000, 32'h0,         4'hF,    12'h000, 32'h0};
    vecs[9]  = '{"base_byte0",  12'h00C, 32'hFFFF_FFFF, 4'b0001, 12'h00C, 32'h1000_00FC};
    vecs[10] = '{"num_nostrb",  12'h008, 32'hDEAD_BEEF, 4'b0000, 12'h008, 32'd100};

    // ---- reset state ----
    #12;
    chk("rst_start_pulse", 32'(start_pulse), 32'd0);
    chk("rst_soft_pulse", 32'(soft_reset_pulse), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    rd(12'h000, v); chk("rst_ctrl", v, 32'h0);
    rd(12'h004, v); chk("rst_root", v, 32'h0);
    rd(12'h008, v); chk("rst_num", v, 32'h0);
    rd(12'h00C, v); chk("rst_base", v, 32'h0);
    rd(12'h01C, v); chk("rst_irqstat", v, 32'h0);

    // ---- table-driven register vectors ----
    foreach (vecs[i]) begin
      wr(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb);
      rd(vecs[i].raddr, v);
      chk(vecs[i].name, v, vecs[i].exp);
    end
    chk("root_port", root_node, 32'd5);
    chk("base_port", graph_base, 32'h1000_00FC);

    // START bit without byte-0 strobe does nothing
    wr(12'h000, 32'h1, 4'b1110);
    chk("start_nostrb", 32'(start_pulse), 32'd0);

    // ---- normal run ----
    wr(12'h000, 32'h5, 4'hF);
    chk("start_pulse_hi", 32'(start_pulse), 32'd1);
    rd(12'h000, v); chk("state_launch", v, 32'h0001_0004);
    @(posedge clk); #1;
    chk("start_pulse_lo", 32'(start_pulse), 32'd0);
    rd(12'h000, v); chk("state_run", v, 32'h0002_0004);
    busy = 1'b1;
    repeat (10) @(posedge clk);
    #1; busy = 1'b0;
    wait_irq(10);
    rd(12'h01C, v); chk("irq_pending", v, 32'h1);
    rd(12'h000, v); chk("state_idle", v, 32'h4);
    wr(12'h01C, 32'h1, 4'hF);
    chk("irq_w1c", 32'(irq), 32'd0);

    // ---- writes while running are locked out ----
    wr(12'h000, 32'h5, 4'hF);
    chk("start2_pulse", 32'(start_pulse), 32'd1);
    busy = 1'b1;
    @(posedge clk); #1;
    wr(12'h000, 32'h5, 4'hF);
    chk("start_busy_nopulse", 32'(start_pulse), 32'd0);
    wr(12'h004, 32'd7, 4'hF);
    rd(12'h004, v); chk("root_locked", v, 32'd5);
    rd(12'h000, v); chk("rej_set_run", v, 32'h0002_0104);
    wr(12'h000, 32'h104, 4'hF);
    rd(12'h000, v); chk("rej_w1c", v, 32'h0002_0004);
    busy = 1'b0;
    wait_irq(10);
    wr(12'h01C, 32'h1, 4'hF);

    // ---- invalid start configurations ----
    wr(12'h008, 32'd0, 4'hF);
    wr(12'h000, 32'h5, 4'hF);
    chk("num0_nopulse", 32'(start_pulse), 32'd0);
    @(posedge clk); #1;
    rd(12'h000, v); chk("num0_rej_idle", v, 32'h104);
    wr(12'h000, 32'h104, 4'hF);
    wr(12'h008, 32'd100, 4'hF);
    wr(12'h004, 32'd100, 4'hF);
    // Rejected START and W1C of the flag in the same write: flag stays set
    wr(12'h000, 32'h105, 4'hF);
    chk("root_oob_nopulse", 32'(start_pulse), 32'd0);
    rd(12'h000, v); chk("rej_set_wins", v, 32'h104);
    wr(12'h000, 32'h104, 4'hF);
    wr(12'h004, 32'd5, 4'hF);

    // ---- soft reset during RUN ----
    wr(12'h000, 32'h5, 4'hF);
    busy = 1'b1;
    @(posedge clk); #1;
    wr(12'h000, 32'h7, 4'hF);
    chk("soft_pulse_hi", 32'(soft_reset_pulse), 32'd1);
    chk("soft_no_start", 32'(start_pulse), 32'd0);
    rd(12'h000, v); chk("soft_idle", v, 32'h4);
    rd(12'h008, v); chk("soft_cfg_kept", v, 32'd100);
    @(posedge clk); #1;
    chk("soft_pulse_lo", 32'(soft_reset_pulse), 32'd0);
    busy = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rd(12'h01C, v); chk("soft_no_irq", v, 32'h0);
    // START and SOFT_RESET together while idle: soft reset only
    wr(12'h000, 32'h7, 4'hF);
    chk("both_soft", 32'(soft_reset_pulse), 32'd1);
    chk("both_no_start", 32'(start_pulse), 32'd0);
    @(posedge clk); #1;
    rd(12'h000, v); chk("both_idle", v, 32'h4);

    // ---- watchdog completion, irq set vs W1C in DRAIN ----
    done = 1'b1;
    wr(12'h000, 32'h5, 4'hF);
    cyc = 0;
    rd(12'h000, v);
    while (v[17:16] != 2'd3 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      rd(12'h000, v);
    end
    chk("wd_drain_seen", 32'(v[17:16]), 32'd3);
    chk("wd_not_early", 32'(cyc >= 16), 32'd1);
    wr(12'h01C, 32'h1, 4'hF);
    rd(12'h01C, v); chk("irq_set_wins", v, 32'h1);
    done = 1'b0;
    wr(12'h000, 32'h0, 4'hF);
    chk("irq_gated", 32'(irq), 32'd0);
    rd(12'h01C, v); chk("pending_ungated", v, 32'h1);
    wr(12'h000, 32'h4, 4'hF);
    chk("irq_ungated", 32'(irq), 32'd1);
    wr(12'h01C, 32'h1, 4'hF);

    // ---- randomized register traffic against the model (FSM stays idle) ----
    m_root = 32'd5; m_num = 32'd100; m_base = 32'h1000_00FC;
    m_irq_en = 1'b1; m_rej = 1'b0; m_pend = 1'b0;
    for (int n = 0; n < 150; n++) begin
      logic [11:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      case ($urandom_range(0, 7))
        0: a = 12'h000;
        1: a = 12'h004;
        2: a = 12'h008;
        3: a = 12'h00C;
        4: a = 12'h01C;
        5: a = 12'h010;
        6: a = 12'h018;
        default: a = 12'($urandom);
      endcase
      d = $urandom;
      s = 4'($urandom);
      if (a == 12'h000) d[1:0] = 2'b00;
      wr(a, d, s);
      case (a)
        12'h000: begin
          if (s[0]) m_irq_en = d[2];
          if (s[1] && d[8]) m_rej = 1'b0;
        end
        12'h004: m_root = merge(m_root, d, s);
        12'h008: m_num = merge(m_num, d, s);
        12'h00C: m_base = merge(m_base, d, s) & 32'hFFFF_FFFC;
        12'h01C: if (s[0] && d[0]) m_pend = 1'b0;
        default: ;
      endcase
      rd(a, v); chk("rand_rd", v, model_read(a));
      chk("rand_irq", 32'(irq), 32'(m_pend & m_irq_en));
    end
    chk("rand_root_port", root_node, m_root);
    chk("rand_num_port", num_nodes, m_num);
    chk("rand_base_port", graph_base, m_base);

    // ---- asynchronous reset while start_pulse is high ----
    wr(12'h004, 32'd1, 4'hF);
    wr(12'h008, 32'd10, 4'hF);
    wr(12'h000, 32'h5, 4'hF);
    chk("arst_pre_pulse", 32'(start_pulse), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_start", 32'(start_pulse), 32'd0);
    chk("arst_root", root_node, 32'd0);
    chk("arst_num", num_nodes, 32'd0);
    chk("arst_irq", 32'(irq), 32'd0);
    rd(12'h000, v); chk("arst_ctrl", v, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_after_start", 32'(start_pulse), 32'd0);
    chk("arst_after_soft", 32'(soft_reset_pulse), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
